// File: rtl/memory_writeback_if.sv
// Bundles the write-back controller's control, pixel-stream and BRAM write-port signals.
// The slave modport is the controller's view; the master modport belongs to whatever drives it.
interface memory_writeback_if;
    logic        start_i;
    logic [17:0] base_addr_i;
    logic [9:0]  rows_i;
    logic [9:0]  cols_i;
    logic [7:0]  data_i;
    logic        data_en_i;
    logic        ready_o;
    logic        done_o;
    logic [9:0]  cnt_img_row_o;
    logic [9:0]  cnt_img_col_o;
    logic        ena_o;
    logic        wea_o;
    logic [17:0] addr_o;
    logic [7:0]  d2mem_o;
    logic        ovf_o;

    modport master (
        output start_i, base_addr_i, rows_i, cols_i, data_i, data_en_i,
        input  ready_o, done_o, cnt_img_row_o, cnt_img_col_o,
        input  ena_o, wea_o, addr_o, d2mem_o, ovf_o
    );

    modport slave (
        input  start_i, base_addr_i, rows_i, cols_i, data_i, data_en_i,
        output ready_o, done_o, cnt_img_row_o, cnt_img_col_o,
        output ena_o, wea_o, addr_o, d2mem_o, ovf_o
    );
endinterface

// File: rtl/memory_writeback.sv
// Write-side BRAM controller: stores a rows x cols pixel region at base_addr with line stride MAX_COL.
// Optional sticky overflow flag for beats arriving outside RUN is enabled by defining WB_BOUND_CHECK_EN.
module memory_writeback #(
    parameter int MAX_ROW = 360,
    parameter int MAX_COL = 540
) (
    input  logic               clk,
    input  logic               rst_n,
    memory_writeback_if.slave  bus
);
    localparam logic [9:0]  MAX_ROW_C    = 10'(MAX_ROW);
    localparam logic [9:0]  MAX_COL_C    = 10'(MAX_COL);
    localparam logic [17:0] LINE_STRIDE  = 18'(MAX_COL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  rows_q, rows_d;
    logic [9:0]  cols_q, cols_d;
    logic [9:0]  row_q, row_d;
    logic [9:0]  col_q, col_d;
    logic [17:0] line_base_q, line_base_d;

    logic        wr;
    logic        last_col;
    logic        last_row;
    logic [9:0]  rows_clamped;
    logic [9:0]  cols_clamped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            line_base_q <= '0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            row_q       <= row_d;
            col_q       <= col_d;
            line_base_q <= line_base_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        row_d        = row_q;
        col_d        = col_q;
        line_base_d  = line_base_q;

        wr           = bus.data_en_i && (state_q == RUN);
        last_col     = (col_q == cols_q - 10'd1);
        last_row     = (row_q == rows_q - 10'd1);
        rows_clamped = (bus.rows_i > MAX_ROW_C) ? MAX_ROW_C : bus.rows_i;
        cols_clamped = (bus.cols_i > MAX_COL_C) ? MAX_COL_C : bus.cols_i;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    rows_d      = rows_clamped;
                    cols_d      = cols_clamped;
                    row_d       = '0;
                    col_d       = '0;
                    line_base_d = bus.base_addr_i;
                    state_d     = (rows_clamped == '0 || cols_clamped == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (wr) begin
                    if (last_col) begin
                        col_d       = '0;
                        line_base_d = line_base_q + LINE_STRIDE;
                        // Row counter wraps to 0 on the final pixel so it rests at 0/0 afterwards.
                        if (last_row) begin
                            row_d   = '0;
                            state_d = DONE;
                        end else begin
                            row_d   = row_q + 10'd1;
                        end
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // BRAM port is combinational from the beat: zero write latency.
    assign bus.ready_o       = (state_q == RUN);
    assign bus.done_o        = (state_q == DONE);
    assign bus.cnt_img_row_o = row_q;
    assign bus.cnt_img_col_o = col_q;
    assign bus.ena_o         = wr;
    assign bus.wea_o         = wr;
    assign bus.addr_o        = line_base_q + {8'd0, col_q};
    assign bus.d2mem_o       = wr ? bus.data_i : 8'd0;

`ifdef WB_BOUND_CHECK_EN
    logic ovf_q, ovf_d;

    // An accepted start clears the flag, but a stray beat in that same cycle still sets it.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == IDLE && bus.start_i) begin
            ovf_d = 1'b0;
        end
        if (bus.data_en_i && state_q != RUN) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf_o = ovf_q;
`else
    assign bus.ovf_o = 1'b0;
`endif

endmodule
